// File: rtl/mem_stage_access.sv
// MEM pipeline stage: data-memory access over a req/ack handshake with timeout,
// byte-lane steering for stores and sign/zero extension for loads.
module mem_stage_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_req_t;

    state_t               state, state_nxt;
    mem_req_t             req;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           off;
    logic                 is_mem, legal, aligned, timeout;
    logic [3:0]           be;
    logic [31:0]          wdata, load_data;
    logic [15:0]          shifted;

    assign off     = ex_alu_result_i[1:0];
    assign is_mem  = ex_mem_read_i | ex_mem_write_i;
    assign timeout = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Store wins when both read and write are flagged.
    always_comb begin
        legal = 1'b0;
        if (ex_mem_write_i) legal = ex_funct3_i inside {3'b000, 3'b001, 3'b010};
        else                legal = ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        aligned = 1'b0;
        be      = 4'b1111;
        case (ex_funct3_i[1:0])
            2'b00: begin aligned = 1'b1;         be = 4'b0001 << off; end
            2'b01: begin aligned = ~off[0];      be = 4'b0011 << off; end
            2'b10: begin aligned = (off == 2'b00); be = 4'b1111;      end
            default: begin aligned = 1'b0;       be = 4'b1111;        end
        endcase
        wdata = ex_store_data_i << {off, 3'b000};
    end

    always_comb begin
        shifted   = 16'(dmem_rdata_i >> {req.off, 3'b000});
        load_data = dmem_rdata_i;
        case (req.funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (ex_valid_i && is_mem && legal && aligned) state_nxt = ACCESS;
        end else begin
            if (dmem_ack_i || timeout) state_nxt = IDLE;
        end
    end

    always_comb begin
        stall_o    = (state == ACCESS);
        dmem_req_o = (state == ACCESS);
    end

    assign dmem_we_o    = req.we;
    assign dmem_addr_o  = req.addr;
    assign dmem_wdata_o = req.wdata;
    assign dmem_be_o    = req.be;

    always_ff @(posedge clk) begin
        if (!reset) begin
            req            <= '0;
            cnt            <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            misalign_o     <= 1'b0;
            bus_err_o      <= 1'b0;
        end else begin
            misalign_o     <= 1'b0;
            bus_err_o      <= 1'b0;
            wb_reg_write_o <= 1'b0;
            if (state == IDLE) begin
                wb_valid_o <= ex_valid_i;
                if (ex_valid_i) begin
                    wb_rd_o <= ex_rd_i;
                    if (!is_mem) begin
                        wb_reg_write_o <= ex_reg_write_i;
                        wb_data_o      <= ex_alu_result_i;
                    end else if (legal && aligned) begin
                        req        <= '{addr: {ex_alu_result_i[31:2], 2'b00}, wdata: wdata, be: be,
                                        we: ex_mem_write_i, funct3: ex_funct3_i, off: off,
                                        rd: ex_rd_i, reg_write: ex_reg_write_i};
                        cnt        <= '0;
                        wb_valid_o <= 1'b0;
                    end else begin
                        misalign_o <= 1'b1;
                        wb_data_o  <= '0;
                    end
                end
            end else begin
                wb_valid_o <= 1'b0;
                if (dmem_ack_i) begin
                    wb_valid_o     <= 1'b1;
                    wb_rd_o        <= req.rd;
                    wb_reg_write_o <= ~req.we & req.reg_write;
                    wb_data_o      <= req.we ? 32'd0 : load_data;
                end else if (timeout) begin
                    wb_valid_o <= 1'b1;
                    bus_err_o  <= 1'b1;
                    wb_rd_o    <= req.rd;
                    wb_data_o  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: single-cycle vector table plus
// hand-written multi-cycle access, timeout and reset sequences.
module tb_mem_stage_access;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_reg_write_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_alu_result_i, ex_store_data_i;
    logic [4:0]  ex_rd_i;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        wb_valid_o, wb_reg_write_o, misalign_o, bus_err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int ncmp = 0;
    int nerr = 0;

    mem_stage_access #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
        .ex_funct3_i(ex_funct3_i), .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
        .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd_en, wr_en, regw;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic        e_wbv, e_regw, e_mis, chk_fields;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw);
        ex_valid_i = v; ex_mem_read_i = r; ex_mem_write_i = w; ex_funct3_i = f3;
        ex_alu_result_i = a; ex_store_data_i = sd; ex_rd_i = rd; ex_reg_write_i = rw;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Issue an aligned memory op, wait lat cycles without ack, then ack and check WB.
    task automatic mem_op(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input int lat, input logic [31:0] rdata,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_data, input logic e_regw);
        drive(1'b1, ~w, w, f3, a, sd, rd, rw);
        step();
        idle_in();
        chk({name, "_addr"}, dmem_addr_o, {a[31:2], 2'b00});
        chk({name, "_be"}, {28'd0, dmem_be_o}, {28'd0, e_be});
        chk({name, "_we"}, {31'd0, dmem_we_o}, {31'd0, w});
        if (w) chk({name, "_wdata"}, dmem_wdata_o, e_wdata);
        chk({name, "_wbv_busy"}, {31'd0, wb_valid_o}, 32'd0);
        for (int i = 0; i < lat; i++) begin
            chk({name, "_stall"}, {31'd0, stall_o}, 32'd1);
            chk({name, "_req"}, {31'd0, dmem_req_o}, 32'd1);
            step();
        end
        chk({name, "_stall_last"}, {31'd0, stall_o}, 32'd1);
        dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        step();
        dmem_ack_i = 1'b0;
        chk({name, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        chk({name, "_wbv"}, {31'd0, wb_valid_o}, 32'd1);
        chk({name, "_regw"}, {31'd0, wb_reg_write_o}, {31'd0, e_regw});
        chk({name, "_rd"}, {27'd0, wb_rd_o}, {27'd0, rd});
        chk({name, "_data"}, wb_data_o, e_data);
        chk({name, "_buserr"}, {31'd0, bus_err_o}, 32'd0);
    endtask

    initial begin
        //          valid rd wr regw f3      addr          sdata  rd   wbv regw mis chk rd    data
        vecs[0] = '{1, 0, 0, 1, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1, 1, 0, 1, 5'd5, 32'h0000_1234};
        vecs[1] = '{1, 0, 0, 0, 3'b010, 32'hDEAD_BEEF, 32'd0, 5'd7, 1, 0, 0, 1, 5'd7, 32'hDEAD_BEEF};
        vecs[2] = '{0, 0, 0, 1, 3'b000, 32'h0000_0055, 32'd0, 5'd9, 0, 0, 0, 0, 5'd0, 32'd0};
        vecs[3] = '{1, 1, 0, 1, 3'b010, 32'h0000_0041, 32'd0, 5'd3, 1, 0, 1, 1, 5'd3, 32'd0};
        vecs[4] = '{1, 1, 0, 1, 3'b001, 32'h0000_0043, 32'd0, 5'd4, 1, 0, 1, 1, 5'd4, 32'd0};
        vecs[5] = '{1, 0, 1, 0, 3'b010, 32'h0000_0102, 32'h1, 5'd6, 1, 0, 1, 1, 5'd6, 32'd0};
        vecs[6] = '{1, 1, 0, 1, 3'b011, 32'h0000_0000, 32'd0, 5'd8, 1, 0, 1, 1, 5'd8, 32'd0};
        vecs[7] = '{1, 0, 1, 0, 3'b100, 32'h0000_0000, 32'h2, 5'd10, 1, 0, 1, 1, 5'd10, 32'd0};
        vecs[8] = '{1, 1, 1, 1, 3'b100, 32'h0000_0000, 32'h3, 5'd11, 1, 0, 1, 1, 5'd11, 32'd0};
        vecs[9] = '{1, 0, 0, 1, 3'b000, 32'hCAFE_0001, 32'd0, 5'd31, 1, 1, 0, 1, 5'd31, 32'hCAFE_0001};

        reset = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
        idle_in();
        step(); step();
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_regw", {31'd0, wb_reg_write_o}, 32'd0);
        chk("rst_rd", {27'd0, wb_rd_o}, 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_mis", {31'd0, misalign_o}, 32'd0);
        chk("rst_buserr", {31'd0, bus_err_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
        reset = 1'b1;

        // Single-cycle vectors: ALU ops, bubble, misaligned/illegal drops
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].rd_en, vecs[i].wr_en, vecs[i].f3, vecs[i].addr,
                  vecs[i].sdata, vecs[i].rd, vecs[i].regw);
            step();
            chk($sformatf("v%0d_wbv", i), {31'd0, wb_valid_o}, {31'd0, vecs[i].e_wbv});
            chk($sformatf("v%0d_regw", i), {31'd0, wb_reg_write_o}, {31'd0, vecs[i].e_regw});
            chk($sformatf("v%0d_mis", i), {31'd0, misalign_o}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, 32'd0);
            chk($sformatf("v%0d_req", i), {31'd0, dmem_req_o}, 32'd0);
            if (vecs[i].chk_fields) begin
                chk($sformatf("v%0d_rd", i), {27'd0, wb_rd_o}, {27'd0, vecs[i].e_rd});
                chk($sformatf("v%0d_data", i), wb_data_o, vecs[i].e_data);
            end
        end
        idle_in();
        step();
        chk("mis_pulse_clr", {31'd0, misalign_o}, 32'd0);

        // LB 0x103: 3 waiting cycles + ack cycle = stall high 4 cycles
        mem_op("lb", 1'b0, 3'b000, 32'h103, 32'd0, 5'd12, 1'b1, 3, 32'h80FF_FFFF,
               4'b1000, 32'd0, 32'hFFFF_FF80, 1'b1);
        mem_op("sh", 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 5'd13, 1'b1, 1, 32'hFFFF_FFFF,
               4'b1100, 32'hBEEF_0000, 32'd0, 1'b0);
        mem_op("sb", 1'b1, 3'b000, 32'h1, 32'h0000_00A5, 5'd14, 1'b0, 0, 32'd0,
               4'b0010, 32'h0000_A500, 32'd0, 1'b0);
        mem_op("lhu", 1'b0, 3'b101, 32'h2, 32'd0, 5'd15, 1'b1, 2, 32'h8001_0000,
               4'b1100, 32'd0, 32'h0000_8001, 1'b1);
        mem_op("lh", 1'b0, 3'b001, 32'h2, 32'd0, 5'd16, 1'b1, 0, 32'h8001_0000,
               4'b1100, 32'd0, 32'hFFFF_8001, 1'b1);
        mem_op("lbu", 1'b0, 3'b100, 32'h1, 32'd0, 5'd17, 1'b1, 1, 32'h0000_F000,
               4'b0010, 32'd0, 32'h0000_00F0, 1'b1);
        mem_op("sw", 1'b1, 3'b010, 32'h44, 32'h1234_5678, 5'd18, 1'b1, 0, 32'd0,
               4'b1111, 32'h1234_5678, 32'd0, 1'b0);

        // Held instruction behind a load is processed right after the access returns
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd20, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'd0, 5'd9, 1'b1);
        step();
        chk("held_stall", {31'd0, stall_o}, 32'd1);
        chk("held_wbv_busy", {31'd0, wb_valid_o}, 32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hA5A5_5A5A;
        step();
        dmem_ack_i = 1'b0;
        chk("held_lw_data", wb_data_o, 32'hA5A5_5A5A);
        chk("held_lw_rd", {27'd0, wb_rd_o}, 32'd20);
        step();
        chk("held_alu_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("held_alu_rd", {27'd0, wb_rd_o}, 32'd9);
        chk("held_alu_data", wb_data_o, 32'h0000_0055);
        idle_in();

        // Timeout: no ack for T cycles
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 5'd4, 1'b1);
        step();
        idle_in();
        for (int i = 1; i < T; i++) begin
            if (stall_o !== 1'b1 || bus_err_o !== 1'b0) chk($sformatf("to_wait%0d", i),
                {30'd0, stall_o, bus_err_o}, 32'd2);
            step();
        end
        chk("to_stall_last", {31'd0, stall_o}, 32'd1);
        step();
        chk("to_buserr", {31'd0, bus_err_o}, 32'd1);
        chk("to_stall", {31'd0, stall_o}, 32'd0);
        chk("to_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("to_regw", {31'd0, wb_reg_write_o}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0777, 32'd0, 5'd2, 1'b1);
        step();
        chk("to_buserr_clr", {31'd0, bus_err_o}, 32'd0);
        chk("to_alu_data", wb_data_o, 32'h0000_0777);
        chk("to_alu_regw", {31'd0, wb_reg_write_o}, 32'd1);

        // Ack in IDLE is ignored
        idle_in();
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        chk("idle_ack_stall", {31'd0, stall_o}, 32'd0);
        chk("idle_ack_wbv", {31'd0, wb_valid_o}, 32'd0);

        // Ack coincides with the timeout cycle: ack wins
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 5'd21, 1'b1);
        step();
        idle_in();
        for (int i = 1; i < T; i++) step();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1122_3344;
        step();
        dmem_ack_i = 1'b0;
        chk("race_buserr", {31'd0, bus_err_o}, 32'd0);
        chk("race_regw", {31'd0, wb_reg_write_o}, 32'd1);
        chk("race_data", wb_data_o, 32'h1122_3344);

        // Reset in the middle of an access
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h1, 32'd0, 5'd6, 1'b1);
        step();
        idle_in();
        chk("mrst_busy", {31'd0, stall_o}, 32'd1);
        reset = 1'b0;
        step();
        chk("mrst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("mrst_stall", {31'd0, stall_o}, 32'd0);
        chk("mrst_wbv", {31'd0, wb_valid_o}, 32'd0);
        reset = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        step();
        dmem_ack_i = 1'b0;
        chk("late_ack_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
        chk("late_ack_regw", {31'd0, wb_reg_write_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Consumes the EX/MEM pipeline register outputs: ALU result as address, store data, control bits, destination register.
- Performs the data-memory access over a req/ack handshake; memory latency is variable.
- Stalls the upstream pipeline while an access is outstanding.
- Produces the registered MEM/WB fields, with byte-lane steering and load sign/zero extension.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS without ack before the access is aborted. Minimum 1.
- CNT_WIDTH, 5: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid_i  in  1  EX/MEM slot holds a real instruction.
- ex_mem_read_i  in  1  instruction is a load.
- ex_mem_write_i  in  1  instruction is a store.
- ex_funct3_i  in  3  access size/sign (RV32I load/store funct3).
- ex_alu_result_i  in  32  byte address for memory ops; writeback data otherwise.
- ex_store_data_i  in  32  rs2 value for stores.
- ex_rd_i  in  5  destination register.
- ex_reg_write_i  in  1  instruction writes rd.
- stall_o  out  1  upstream must hold EX/MEM contents.
- dmem_req_o  out  1  memory request valid.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  32  byte address, word-aligned: low 2 bits forced 0.
- dmem_wdata_o  out  32  store data shifted into byte lanes.
- dmem_be_o  out  4  byte enables.
- dmem_ack_i  in  1  memory completes request this cycle; dmem_rdata_i valid.
- dmem_rdata_i  in  32  read word.
- wb_valid_o  out  1  MEM/WB holds a real instruction.
- wb_reg_write_o  out  1  register-file write enable for WB.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  32  writeback data.
- misalign_o  out  1  one-cycle pulse: misaligned or illegal-size access dropped.
- bus_err_o  out  1  one-cycle pulse: access aborted by timeout.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; counter 0; every output register 0.
  - stall_o and dmem_req_o are 0 the following cycle.
  - Reset mid-ACCESS abandons the request with no WB result.
- States: IDLE and ACCESS.
  - stall_o = (state==ACCESS), combinational.
  - dmem_req_o = (state==ACCESS).
- IDLE, ex_valid_i=0: at the edge, wb_valid_o=0 and wb_reg_write_o=0 (bubble).
- IDLE, valid, no mem op: at the edge, wb_valid_o=1, wb_reg_write_o=ex_reg_write_i, wb_rd_o=ex_rd_i, wb_data_o=ex_alu_result_i. Latency 1 cycle.
- IDLE, valid mem op: write has priority when both read and write are set.
  - Alignment check: funct3 000/100 always aligned; 001/101 need addr[0]=0; 010 needs addr[1:0]=00.
  - Load funct3 011/110/111 and store funct3 other than 000/001/010 are illegal.
  - Aligned and legal: latch addr, be, wdata, funct3, offset, rd, reg_write, we; state→ACCESS; counter=0; wb_valid_o=0.
  - Misaligned or illegal: no memory access; misalign_o=1 for one cycle; wb_valid_o=1; wb_reg_write_o=0; wb_rd_o=ex_rd_i; wb_data_o=0.
- Byte enables, with off=addr[1:0]:
  - byte: 0001<<off.
  - half: 0011<<off.
  - word: 1111.
  - wdata = store_data << (8*off).
- ACCESS: request fields are held stable until ack; ex_* inputs are ignored.
  - dmem_ack_i=1: state→IDLE at that edge; wb_valid_o=1; wb_rd_o=latched rd.
    - Load: wb_reg_write_o=latched reg_write; wb_data_o = extracted dmem_rdata_i >> (8*off), sign-extended for 000/001, zero-extended for 100/101, full word for 010.
    - Store: wb_reg_write_o=0 and wb_data_o=0.
  - No ack: counter increments each cycle. When counter==TIMEOUT_CYCLES-1 without ack, state→IDLE; bus_err_o=1 for one cycle; wb_valid_o=1; wb_reg_write_o=0.
  - Ack and timeout in the same cycle: ack wins.
  - Instruction held upstream is processed in the first IDLE cycle after return. A mem op always costs at least 2 cycles plus memory latency.
- dmem_ack_i while in IDLE is ignored.
- misalign_o and bus_err_o are registered; they are 0 in every other cycle.

Test Plan:
- ALU op, ex_alu_result_i=0x1234, rd=5, reg_write=1 → next cycle wb_valid_o=1, wb_rd_o=5, wb_data_o=0x1234, stall_o never 1.
- LB addr 0x103, ack after 3 cycles with rdata 0x80FFFFFF → dmem_addr_o=0x100, be=1000; stall_o high 4 cycles; wb_data_o=0xFFFFFF80.
- SH addr 0x22, store data 0x0000BEEF, ack after 1 cycle → be=1100, wdata=0xBEEF0000, dmem_we_o=1; wb_reg_write_o=0.
- LW addr 0x41 → no dmem_req_o; misalign_o pulses; wb_reg_write_o=0.
- LW with no ack for TIMEOUT_CYCLES → bus_err_o pulses; state IDLE; next ALU op completes normally.
- reset=0 during ACCESS → next cycle dmem_req_o=0, stall_o=0, wb_valid_o=0; late ack ignored.
